// File: rtl/epf_pkg.sv
// epf_pkg: shared FSM type, reciprocal table and absolute-difference helper for the sigma filter
package epf_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int RCP_W_DEF = 16;

    function automatic int unsigned rcp_entry(input int unsigned n, input int unsigned w);
        return ((32'd1 << w) + n / 2) / n;
    endfunction

    localparam int unsigned RCP_TABLE [1:9] = '{
        rcp_entry(1, RCP_W_DEF), rcp_entry(2, RCP_W_DEF), rcp_entry(3, RCP_W_DEF),
        rcp_entry(4, RCP_W_DEF), rcp_entry(5, RCP_W_DEF), rcp_entry(6, RCP_W_DEF),
        rcp_entry(7, RCP_W_DEF), rcp_entry(8, RCP_W_DEF), rcp_entry(9, RCP_W_DEF)
    };

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/epf_line_buf.sv
// epf_line_buf: enable-gated shift-register line buffer, output is the sample written DEPTH shifts ago
module epf_line_buf #(
    parameter int DEPTH = 258,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift one position per enabled cycle; holds through stalls.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end
    end

    assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/epf_stream_core.sv
// epf_stream_core: streaming 3x3 sigma filter over a padded raster frame; EPF_EDGE_CNT_EN adds edge_cnt
module epf_stream_core
    import epf_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8,
    parameter int RCP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] thresh,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    output logic             m_valid,
    output logic [PIX_W-1:0] m_data,
    output logic             busy,
    output logic             done
`ifdef EPF_EDGE_CNT_EN
    ,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_cnt
`endif
);

    localparam int CW = $clog2(IMG_W + 2);
    localparam int RW = $clog2(IMG_H + 2);
    localparam int SW = PIX_W + 4;
    localparam int PW = SW + RCP_W + 1;
    localparam int unsigned RCP [10] = '{
        32'd0,
        rcp_entry(1, RCP_W), rcp_entry(2, RCP_W), rcp_entry(3, RCP_W),
        rcp_entry(4, RCP_W), rcp_entry(5, RCP_W), rcp_entry(6, RCP_W),
        rcp_entry(7, RCP_W), rcp_entry(8, RCP_W), rcp_entry(9, RCP_W)
    };
    localparam logic [PW-1:0] HALF = PW'(1) << (RCP_W - 1);
    localparam logic [PW-1:0] PMAX = PW'((1 << PIX_W) - 1);

    state_t           state_d, state_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [PIX_W-1:0] thresh_q, lb0, lb1, m_data_q, m_data_d;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] tap1_q [9];
    logic [8:0]       hit;
    logic [3:0]       cnt_d, cnt1_q, cnt2_q;
    logic [SW-1:0]    sum_d, sum2_q;
    logic [PW-1:0]    quo;
    logic             win_v_q, v1_q, v2_q, m_valid_q;
    logic             go, accept, last_col, last_row;

    assign go       = (state_q == IDLE) && start;
    assign accept   = (state_q == RUN) && s_valid;
    assign last_col = col_q == CW'(IMG_W + 1);
    assign last_row = row_q == RW'(IMG_H + 1);
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;

    epf_line_buf #(.DEPTH(IMG_W + 2), .WIDTH(PIX_W)) u_lb0 (
        .clk  (clk),
        .en_i (accept),
        .d_i  (s_data),
        .q_o  (lb0)
    );

    epf_line_buf #(.DEPTH(IMG_W + 2), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .en_i (accept),
        .d_i  (lb0),
        .q_o  (lb1)
    );

    // Next state plus the state-decoded handshake and status outputs.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE:  state_d = start ? RUN : IDLE;
            RUN: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && last_col && last_row) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!(win_v_q || v1_q || v2_q || m_valid_q)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // S1 combinational: closeness mask against the centre tap and its population count.
    always_comb begin
        hit   = '0;
        cnt_d = '0;
        for (int i = 0; i < 9; i++) begin
            hit[i] = abs_diff(16'(win_q[i]), 16'(win_q[4])) <= 16'(thresh_q);
            cnt_d  = cnt_d + 4'(hit[i]);
        end
    end

    // S2/S3 combinational: masked-tap sum, then reciprocal multiply with rounding and saturation.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) sum_d = sum_d + SW'(tap1_q[i]);
        quo      = (PW'(sum2_q) * PW'(RCP[cnt2_q]) + HALF) >> RCP_W;
        m_data_d = (quo > PMAX) ? '1 : quo[PIX_W-1:0];
    end

    // Window columns shift on accepts only; the datapath stages advance every cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]   <= win_q[3*r+1];
                win_q[3*r+1] <= win_q[3*r+2];
            end
            win_q[2] <= lb1;
            win_q[5] <= lb0;
            win_q[8] <= s_data;
        end
        for (int i = 0; i < 9; i++) tap1_q[i] <= hit[i] ? win_q[i] : '0;
        cnt1_q <= cnt_d;
        cnt2_q <= cnt1_q;
        sum2_q <= sum_d;
    end

    // State, raster counters, latched threshold and the pipeline valid chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            thresh_q  <= '0;
            win_v_q   <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            win_v_q   <= accept && row_q >= RW'(2) && col_q >= CW'(2);
            v1_q      <= win_v_q;
            v2_q      <= v1_q;
            m_valid_q <= v2_q;
            if (v2_q) m_data_q <= m_data_d;
            if (go) begin
                thresh_q <= thresh;
                col_q    <= '0;
                row_q    <= '0;
            end else if (accept) begin
                col_q <= last_col ? '0 : col_q + 1'b1;
                if (last_col) row_q <= last_row ? '0 : row_q + 1'b1;
            end
        end
    end

`ifdef EPF_EDGE_CNT_EN
    logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_q;

    // Count output pixels whose window rejected at least one tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_q <= '0;
        else if (go) edge_q <= '0;
        else if (v2_q && cnt2_q != 4'd9) edge_q <= edge_q + 1'b1;
    end

    assign edge_cnt = edge_q;
`endif

endmodule

// File: tb/tb_epf_stream_core.sv
// tb_epf_stream_core: randomized frames against a window-level sigma-filter model
module tb_epf_stream_core;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int PW = W + 2;
    localparam int PH = H + 2;
    localparam int N  = W * H;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
    logic [7:0] thresh = '0, s_data = '0;
    logic       s_ready, m_valid, busy, done;
    logic [7:0] m_data;
`ifdef EPF_EDGE_CNT_EN
    logic [$clog2(N+1)-1:0] edge_cnt;
`endif

    always #5 clk = ~clk;

    epf_stream_core #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .RCP_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .thresh  (thresh),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_data  (m_data),
        .busy    (busy),
        .done    (done)
`ifdef EPF_EDGE_CNT_EN
        ,
        .edge_cnt(edge_cnt)
`endif
    );

    int checks = 0, fails = 0;
    int frame [PH][PW];
    int exp_mem [N];
    int got_mem [N];
    int exp_edges, cnt0, sum0;
    int acc_idx = 0, out_idx = 0, n = 0, done_due = -1;
    int lat_q [$];

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void fill_random();
        for (int r = 0; r < PH; r++)
            for (int c = 0; c < PW; c++) frame[r][c] = $urandom_range(0, 255);
    endfunction

    // Sigma filter straight from the definition: average the taps close to the centre.
    function automatic void model(input int thr);
        exp_edges = 0;
        for (int oy = 0; oy < H; oy++)
            for (int ox = 0; ox < W; ox++) begin
                int c, cnt, sum, rcp, v;
                c = frame[oy+1][ox+1];
                cnt = 0;
                sum = 0;
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++) begin
                        int t;
                        t = frame[oy+dy][ox+dx];
                        if ((t > c ? t - c : c - t) <= thr) begin
                            cnt++;
                            sum += t;
                        end
                    end
                rcp = (65536 + cnt / 2) / cnt;
                v = (sum * rcp + 32768) / 65536;
                exp_mem[oy*W+ox] = v > 255 ? 255 : v;
                if (cnt < 9) exp_edges++;
                if (oy == 0 && ox == 0) begin
                    cnt0 = cnt;
                    sum0 = sum;
                end
            end
    endfunction

    // Compare process: every output strobe, its latency, and the done pulse.
    always @(negedge clk) begin
        n++;
        if (!rst_n) begin
            acc_idx = 0;
            out_idx = 0;
            done_due = -1;
            lat_q.delete();
        end else begin
            if (start && !busy) begin
                acc_idx = 0;
                out_idx = 0;
                done_due = -1;
                lat_q.delete();
            end
            if (s_valid && s_ready) begin
                if (acc_idx / PW >= 2 && acc_idx % PW >= 2) lat_q.push_back(n + 4);
                acc_idx++;
            end
            if (m_valid) begin
                int due;
                due = lat_q.size() > 0 ? lat_q.pop_front() : -1;
                chk("latency", n, due);
                if (out_idx < N) begin
                    got_mem[out_idx] = m_data;
                    chk("data", m_data, exp_mem[out_idx]);
                end else chk("extra_strobe", out_idx, N - 1);
                out_idx++;
                if (out_idx == N) done_due = n + 1;
            end else if (lat_q.size() > 0 && lat_q[0] == n) begin
                chk("missing_strobe", 0, 1);
                void'(lat_q.pop_front());
            end
            if (done || n == done_due) chk("done", done, int'(n == done_due));
        end
    end

    task automatic run_frame(input int thr, input int gap, input int poke, input int abort_at);
        int idx;
        bit acc;
        idx = 0;
        model(thr);
        @(posedge clk); #1;
        start = 1'b1;
        thresh = thr[7:0];
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_run", busy, 1);
        chk("ready_run", s_ready, 1);
        while (idx < PW * PH && idx != abort_at) begin
            s_valid = $urandom_range(0, 99) >= gap;
            s_data = frame[idx/PW][idx%PW][7:0];
            start = idx == poke;
            if (idx == poke) thresh = ~thr[7:0];
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (abort_at >= 0) begin
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (12) @(posedge clk);
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_strobes", out_idx, 0);
        end else begin
            for (int k = 0; k < 20 && !done; k++) begin
                @(posedge clk); #1;
            end
            chk("done_seen", done, 1);
            chk("strobes", out_idx, N);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        for (int r = 0; r < PH; r++) for (int c = 0; c < PW; c++) frame[r][c] = 100;
        run_frame(10, 0, -1, -1);
        chk("pin_flat_model", exp_mem[0], 100);
        chk("pin_flat_dut", got_mem[N-1], 100);
`ifdef EPF_EDGE_CNT_EN
        chk("edge_flat", edge_cnt, 0);
`endif

        for (int r = 0; r < PH; r++) for (int c = 0; c < PW; c++) frame[r][c] = c <= 5 ? 0 : 200;
        run_frame(20, 30, -1, -1);
        chk("pin_step_edges", exp_edges, 16);
        chk("pin_step_l", got_mem[4], 0);
        chk("pin_step_r", got_mem[5], 200);
        chk("pin_step_l7", got_mem[7*W+4], 0);
        chk("pin_step_r7", got_mem[7*W+5], 200);
`ifdef EPF_EDGE_CNT_EN
        chk("edge_step", edge_cnt, 16);
`endif

        fill_random();
        frame[0][0] = 80;  frame[0][1] = 85; frame[0][2] = 95;
        frame[1][0] = 100; frame[1][1] = 90; frame[1][2] = 150;
        frame[2][0] = 30;  frame[2][1] = 90; frame[2][2] = 90;
        run_frame(10, 0, -1, -1);
        chk("pin_centre_cnt", cnt0, 7);
        chk("pin_centre_sum", sum0, 630);
        chk("pin_centre_dut", got_mem[0], 90);

        fill_random();
        run_frame(0, 50, -1, -1);
        fill_random();
        run_frame(255, 50, -1, -1);
        chk("pin_box_edges", exp_edges, 0);
        fill_random();
        run_frame($urandom_range(10, 60), 50, -1, -1);
`ifdef EPF_EDGE_CNT_EN
        chk("edge_rand", edge_cnt, exp_edges);
`endif

        fill_random();
        run_frame(15, 20, 37, -1);

        fill_random();
        run_frame(25, 0, -1, 40);
        fill_random();
        run_frame(25, 50, -1, -1);
`ifdef EPF_EDGE_CNT_EN
        chk("edge_after_abort", edge_cnt, exp_edges);
`endif

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
